// File: rtl/ahb_pkg.sv
// Shared AHB3-Lite encodings and the default-slave state type used by the
// address decoder and its built-in default slave.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        D_IDLE = 2'b00,
        D_ERR1 = 2'b01,
        D_ERR2 = 2'b10
    } def_state_e;

    // NONSEQ and SEQ carry real data; IDLE and BUSY must get a zero-wait OKAY.
    function automatic logic is_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_addr_decoder_if.sv
// Bus-side signals of the AHB address decoder: master address phase inputs,
// one-hot selects, data-phase select and the default-slave response.
interface ahb_addr_decoder_if #(
    parameter int addrWidth = 32
);
    logic [addrWidth-1:0] HADDR;
    logic [1:0]           HTRANS;
    logic                 HREADY;
    logic                 HSEL1;
    logic                 HSEL2;
    logic                 HSEL3;
    logic                 HSEL4;
    logic [1:0]           addr;
    logic                 def_sel;
    logic                 HREADYOUT_DEF;
    logic                 HRESP_DEF;

    modport slave (
        input  HADDR, HTRANS, HREADY,
        output HSEL1, HSEL2, HSEL3, HSEL4, addr, def_sel, HREADYOUT_DEF, HRESP_DEF
    );

    modport master (
        output HADDR, HTRANS, HREADY,
        input  HSEL1, HSEL2, HSEL3, HSEL4, addr, def_sel, HREADYOUT_DEF, HRESP_DEF
    );
endinterface

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: zero-wait OKAY for IDLE/BUSY and the
// two-cycle ERROR response for NONSEQ/SEQ. Outputs come straight from flops.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HREADY,
    input  logic [1:0] HTRANS,
    input  logic       miss,
    output logic       HREADYOUT_DEF,
    output logic       HRESP_DEF
);

    def_state_e state_r;
    def_state_e state_next_s;
    logic       err_start_s;
    logic       hreadyout_next_s;
    logic       hresp_next_s;
    logic       hreadyout_r;
    logic       hresp_r;

    // Next-state and next-output decode
    always_comb begin
        state_next_s     = D_IDLE;
        hreadyout_next_s = 1'b1;
        hresp_next_s     = HRESP_OKAY;
        err_start_s      = HREADY && miss && is_active(HTRANS);
        case (state_r)
            D_IDLE: begin
                if (err_start_s) begin
                    state_next_s = D_ERR1;
                end else begin
                    state_next_s = D_IDLE;
                end
            end
            D_ERR1: begin
                state_next_s = D_ERR2;
            end
            D_ERR2: begin
                if (err_start_s) begin
                    state_next_s = D_ERR1;
                end else begin
                    state_next_s = D_IDLE;
                end
            end
            default: begin
                state_next_s = D_IDLE;
            end
        endcase
        case (state_next_s)
            D_ERR1: begin
                hreadyout_next_s = 1'b0;
                hresp_next_s     = HRESP_ERROR;
            end
            D_ERR2: begin
                hreadyout_next_s = 1'b1;
                hresp_next_s     = HRESP_ERROR;
            end
            default: begin
                hreadyout_next_s = 1'b1;
                hresp_next_s     = HRESP_OKAY;
            end
        endcase
    end

    // State and response registers; reset aborts any ERROR sequence
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r     <= D_IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
        end else begin
            state_r     <= state_next_s;
            hreadyout_r <= hreadyout_next_s;
            hresp_r     <= hresp_next_s;
        end
    end

    assign HREADYOUT_DEF = hreadyout_r;
    assign HRESP_DEF     = hresp_r;

endmodule

// File: rtl/ahb_addr_decoder.sv
// AHB3-Lite address decoder: priority region compare into one-hot HSELn,
// registered data-phase select for the 4-way mux, and a built-in default slave.
module ahb_addr_decoder
    import ahb_pkg::*;
#(
    parameter int                   addrWidth = 32,
    parameter int                   dataWidth = 32,
    parameter logic [addrWidth-1:0] BASE1     = 32'h0000_0000,
    parameter logic [addrWidth-1:0] BASE2     = 32'h1000_0000,
    parameter logic [addrWidth-1:0] BASE3     = 32'h2000_0000,
    parameter logic [addrWidth-1:0] BASE4     = 32'h3000_0000,
    parameter logic [addrWidth-1:0] MASK1     = 32'hF000_0000,
    parameter logic [addrWidth-1:0] MASK2     = 32'hF000_0000,
    parameter logic [addrWidth-1:0] MASK3     = 32'hF000_0000,
    parameter logic [addrWidth-1:0] MASK4     = 32'hF000_0000
)(
    input  logic                HCLK,
    input  logic                HRESET,
    ahb_addr_decoder_if.slave   bus
);

    if ((dataWidth % 8) != 0) begin : g_data_width_check
        $error("dataWidth must be a whole number of bytes");
    end

    logic [3:0] hit_s;
    logic [3:0] sel_s;
    logic [1:0] idx_s;
    logic       miss_s;
    logic [1:0] addr_r;
    logic       def_sel_r;

    // Region compare with slave1 > slave2 > slave3 > slave4 priority
    always_comb begin
        hit_s[0] = ((bus.HADDR & MASK1) == BASE1);
        hit_s[1] = ((bus.HADDR & MASK2) == BASE2);
        hit_s[2] = ((bus.HADDR & MASK3) == BASE3);
        hit_s[3] = ((bus.HADDR & MASK4) == BASE4);
        sel_s    = 4'b0000;
        idx_s    = 2'd0;
        if (hit_s[0]) begin
            sel_s = 4'b0001;
            idx_s = 2'd0;
        end else if (hit_s[1]) begin
            sel_s = 4'b0010;
            idx_s = 2'd1;
        end else if (hit_s[2]) begin
            sel_s = 4'b0100;
            idx_s = 2'd2;
        end else if (hit_s[3]) begin
            sel_s = 4'b1000;
            idx_s = 2'd3;
        end else begin
            sel_s = 4'b0000;
            idx_s = 2'd0;
        end
        miss_s = (hit_s == 4'b0000);
    end

    assign bus.HSEL1 = sel_s[0];
    assign bus.HSEL2 = sel_s[1];
    assign bus.HSEL3 = sel_s[2];
    assign bus.HSEL4 = sel_s[3];

    // Data-phase select: loads on HREADY-qualified address phase, holds on waits
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_r    <= 2'd0;
            def_sel_r <= 1'b0;
        end else if (bus.HREADY) begin
            addr_r    <= idx_s;
            def_sel_r <= miss_s;
        end else begin
            addr_r    <= addr_r;
            def_sel_r <= def_sel_r;
        end
    end

    assign bus.addr    = addr_r;
    assign bus.def_sel = def_sel_r;

    ahb_default_slave u_default_slave (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .HREADY        (bus.HREADY),
        .HTRANS        (bus.HTRANS),
        .miss          (miss_s),
        .HREADYOUT_DEF (bus.HREADYOUT_DEF),
        .HRESP_DEF     (bus.HRESP_DEF)
    );

endmodule
